// File: rtl/parity_frame_checker_if.sv
// Handshake bundle for parity_frame_checker.
// master drives start/abort/bit_in/bit_valid and observes the frame results.
interface parity_frame_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             par_ok;
    logic             par_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output start, abort, bit_in, bit_valid,
        input  busy, done, par_ok, par_err, frame_cnt, err_cnt
    );

    modport slave (
        input  start, abort, bit_in, bit_valid,
        output busy, done, par_ok, par_err, frame_cnt, err_cnt
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial parity checker: XOR of FRAME_LEN data bits plus one parity bit.
// Ports: clk, rst (async high), bus (start/abort/bit_in/bit_valid in; results out).
module parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int ODD       = 0,
    parameter int CNT_W     = 8
) (
    input logic                   clk,
    input logic                   rst,
    parity_frame_checker_if.slave bus
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic ODD_B = (ODD != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

    state_t           state;
    logic             acc;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             done;
    logic             par_ok;
    logic             par_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             r;

    // Seeding acc with ODD folds the expected parity sense into the XOR,
    // so r==0 means "pass" for both parity modes.
    assign r = acc ^ bus.bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            par_ok    <= 1'b0;
            par_err   <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state <= DATA;
                        busy  <= 1'b1;
                        acc   <= ODD_B;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bus.bit_valid) begin
                        acc <= r;
                        idx <= idx + 1'b1;
                        if (idx == LAST) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bus.abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bus.bit_valid) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        par_ok    <= ~r;
                        par_err   <= r;
                        frame_cnt <= frame_cnt + 1'b1;
                        if (r && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.par_ok    = par_ok;
    assign bus.par_err   = par_err;
    assign bus.frame_cnt = frame_cnt;
    assign bus.err_cnt   = err_cnt;
endmodule
